data_memory_responder: RTL and testbench

- Responder end of the processor's data-memory interface: accepts addr/enable/write-enable/write-data from the pipeline and returns 64-bit read data one cycle later.
- Adds a post-reset clear sequencer and a valid/ready preload port used by benches and by the boot loader to fill memory before execution.
- Sits between the processor core and the on-chip data RAM array.

---
 rtl/data_memory_responder_pkg.sv | 10 +
 rtl/data_memory_responder_clear_seq.sv | 43 ++++
 rtl/data_memory_responder.sv | 79 +++++++
 tb/tb_data_memory_responder.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/data_memory_responder_pkg.sv
// Shared constants and state encodings for the data-memory responder.
package data_memory_responder_pkg;
  localparam int DATA_W_DEF    = 64;
  localparam int MEM_ADDR_BITS = 32;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } mem_state_e;
endpackage

// File: rtl/data_memory_responder_clear_seq.sv
// Post-reset clear sequencer: sweeps every word to zero, then enables normal service.
module dmem_clear_seq
  import data_memory_responder_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              i_clk,
  input  logic              i_reset,
  output logic              o_clr_we,
  output logic [ADDR_W-1:0] o_clr_idx,
  output logic              o_run
);
  mem_state_e        r_state;
  logic [ADDR_W-1:0] r_cnt;
  logic              r_run;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_CLEAR;
      r_cnt   <= '0;
      r_run   <= 1'b0;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          r_cnt <= r_cnt + ADDR_W'(1);
          // Last index written this edge; service starts next cycle
          if (&r_cnt) begin
            r_state <= ST_RUN;
            r_run   <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_RUN;
          r_run   <= 1'b1;
        end
      endcase
    end
  end

  assign o_clr_we  = (r_state == ST_CLEAR);
  assign o_clr_idx = r_cnt;
  assign o_run     = r_run;
endmodule

// File: rtl/data_memory_responder.sv
// Data-memory responder: single-port word array, 1-cycle registered reads, preload port, range check.
module data_memory_responder
  import data_memory_responder_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_mem_en,
  input  logic                     i_mem_wr_en,
  input  logic [MEM_ADDR_BITS-1:0] i_mem_addr,
  input  logic [DATA_W-1:0]        i_mem_wdata,
  output logic [DATA_W-1:0]        o_mem_rdata,
  output logic                     o_mem_ready,
  input  logic                     i_pl_valid,
  output logic                     o_pl_ready,
  input  logic [MEM_ADDR_BITS-1:0] i_pl_addr,
  input  logic [DATA_W-1:0]        i_pl_data,
  output logic                     o_oor_err
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;
  logic              r_oor;

  logic              w_clr_we;
  logic [ADDR_W-1:0] w_clr_idx;
  logic              w_run;
  logic              w_mem_inr;
  logic              w_pl_inr;
  logic              w_pl_fire;
  logic              w_cpu_wr;
  logic              w_cpu_rd;

  dmem_clear_seq #(.ADDR_W(ADDR_W)) u_clear_seq (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .o_clr_we (w_clr_we),
    .o_clr_idx(w_clr_idx),
    .o_run    (w_run)
  );

  // Upper address bits must be zero; no aliasing of larger addresses
  assign w_mem_inr = (i_mem_addr[MEM_ADDR_BITS-1:ADDR_W] == '0);
  assign w_pl_inr  = (i_pl_addr[MEM_ADDR_BITS-1:ADDR_W] == '0);

  assign o_pl_ready = w_run & ~i_mem_en;
  assign w_pl_fire  = i_pl_valid & o_pl_ready;
  assign w_cpu_wr   = w_run & i_mem_en & i_mem_wr_en;
  assign w_cpu_rd   = w_run & i_mem_en & ~i_mem_wr_en;

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      if (w_clr_we)
        r_mem[w_clr_idx] <= '0;
      else if (w_cpu_wr && w_mem_inr)
        r_mem[i_mem_addr[ADDR_W-1:0]] <= i_mem_wdata;
      else if (w_pl_fire && w_pl_inr)
        r_mem[i_pl_addr[ADDR_W-1:0]] <= i_pl_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset || !w_run) begin
      r_rdata <= '0;
      r_oor   <= 1'b0;
    end else begin
      if (w_cpu_rd)
        r_rdata <= w_mem_inr ? r_mem[i_mem_addr[ADDR_W-1:0]] : '0;
      r_oor <= (i_mem_en && !w_mem_inr) || (w_pl_fire && !w_pl_inr);
    end
  end

  assign o_mem_rdata = r_rdata;
  assign o_mem_ready = w_run;
  assign o_oor_err   = r_oor;
endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench for data_memory_responder: clear timing, RAW, preload arbitration, range errors, reset restart.
module tb_data_memory_responder;
  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_mem_en;
  logic        i_mem_wr_en;
  logic [31:0] i_mem_addr;
  logic [63:0] i_mem_wdata;
  logic [63:0] o_mem_rdata;
  logic        o_mem_ready;
  logic        i_pl_valid;
  logic        o_pl_ready;
  logic [31:0] i_pl_addr;
  logic [63:0] i_pl_data;
  logic        o_oor_err;

  int checks = 0;
  int errors = 0;
  int n;

  data_memory_responder #(.ADDR_W(8), .DATA_W(64)) dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_mem_en   (i_mem_en),
    .i_mem_wr_en(i_mem_wr_en),
    .i_mem_addr (i_mem_addr),
    .i_mem_wdata(i_mem_wdata),
    .o_mem_rdata(o_mem_rdata),
    .o_mem_ready(o_mem_ready),
    .i_pl_valid (i_pl_valid),
    .o_pl_ready (o_pl_ready),
    .i_pl_addr  (i_pl_addr),
    .i_pl_data  (i_pl_data),
    .o_oor_err  (o_oor_err)
  );

  always #5 i_clk = ~i_clk;

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    i_mem_en = 0; i_mem_wr_en = 0; i_pl_valid = 0;
  endtask

  task automatic rd(input logic [31:0] a);
    i_mem_en = 1; i_mem_wr_en = 0; i_mem_addr = a; i_pl_valid = 0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [63:0] d);
    i_mem_en = 1; i_mem_wr_en = 1; i_mem_addr = a; i_mem_wdata = d; i_pl_valid = 0;
  endtask

  initial begin
    i_reset = 1; i_mem_addr = 0; i_mem_wdata = 0; i_pl_addr = 0; i_pl_data = 0;
    idle();
    step(); step();
    chk("rst_ready", {63'd0, o_mem_ready}, 64'd0);
    chk("rst_rdata", o_mem_rdata, 64'd0);
    chk("rst_pl_ready", {63'd0, o_pl_ready}, 64'd0);
    chk("rst_oor", {63'd0, o_oor_err}, 64'd0);

    // First clear, with processor reads and preload requests landing mid-sweep
    i_reset = 0;
    n = 0;
    while (!o_mem_ready && n < 400) begin
      n++;
      if (n >= 200 && n < 220) begin rd(32'h9); end
      else if (n >= 220 && n < 250) begin
        idle(); i_pl_valid = 1; i_pl_addr = 32'h7; i_pl_data = 64'hAA;
      end else idle();
      #1;
      if (n >= 200 && n < 250) begin
        chk("clr_pl_ready", {63'd0, o_pl_ready}, 64'd0);
        chk("clr_rdata", o_mem_rdata, 64'd0);
        chk("clr_oor", {63'd0, o_oor_err}, 64'd0);
      end
      step();
    end
    idle();
    chk("clear_len", 64'(n), 64'd256);
    chk("ready_up", {63'd0, o_mem_ready}, 64'd1);

    rd(32'h5); step();
    chk("rd5_zero", o_mem_rdata, 64'd0);
    rd(32'h7); step();
    chk("no_clr_preload", o_mem_rdata, 64'd0);

    // Write then read-after-write
    wr(32'h10, 64'hDEADBEEF_CAFEF00D); step();
    chk("wr_rdata_hold", o_mem_rdata, 64'd0);
    rd(32'h10); step();
    chk("raw", o_mem_rdata, 64'hDEADBEEF_CAFEF00D);

    // mem_wr_en without mem_en is ignored
    i_mem_en = 0; i_mem_wr_en = 1; i_mem_addr = 32'h10; i_mem_wdata = 64'h0; step();
    chk("idle_hold", o_mem_rdata, 64'hDEADBEEF_CAFEF00D);
    rd(32'h10); step();
    chk("wr_noen_noop", o_mem_rdata, 64'hDEADBEEF_CAFEF00D);

    // Preload held off by processor traffic
    for (int k = 0; k < 3; k++) begin
      rd(32'h10); i_pl_valid = 1; i_pl_addr = 32'h20; i_pl_data = 64'h1;
      #1;
      chk("pl_blocked", {63'd0, o_pl_ready}, 64'd0);
      step();
    end
    idle(); i_pl_valid = 1;
    #1;
    chk("pl_ready", {63'd0, o_pl_ready}, 64'd1);
    step();
    idle();
    chk("pl_oor_clean", {63'd0, o_oor_err}, 64'd0);
    rd(32'h20); step();
    chk("pl_rd", o_mem_rdata, 64'h1);

    // Out-of-range read, write, preload
    rd(32'h100); step();
    chk("oor_rd_data", o_mem_rdata, 64'd0);
    chk("oor_rd_err", {63'd0, o_oor_err}, 64'd1);
    idle(); step();
    chk("oor_pulse_end", {63'd0, o_oor_err}, 64'd0);
    wr(32'h100, 64'h1234); step();
    chk("oor_wr_err", {63'd0, o_oor_err}, 64'd1);
    rd(32'h0); step();
    chk("oor_wr_dropped", o_mem_rdata, 64'd0);
    chk("inr_no_err", {63'd0, o_oor_err}, 64'd0);
    idle(); i_pl_valid = 1; i_pl_addr = 32'h101; i_pl_data = 64'h77; step();
    idle();
    chk("oor_pl_err", {63'd0, o_oor_err}, 64'd1);
    rd(32'h1); step();
    chk("oor_pl_dropped", o_mem_rdata, 64'd0);

    // Reset mid-RUN restarts the full clear
    wr(32'h3, 64'h55); step();
    rd(32'h3); step();
    chk("rd3", o_mem_rdata, 64'h55);
    idle(); i_reset = 1; step();
    i_reset = 0;
    chk("rerst_ready", {63'd0, o_mem_ready}, 64'd0);
    chk("rerst_rdata", o_mem_rdata, 64'd0);
    n = 0;
    while (!o_mem_ready && n < 400) begin
      n++;
      step();
    end
    chk("reclear_len", 64'(n), 64'd256);
    rd(32'h3); step();
    chk("rd3_cleared", o_mem_rdata, 64'd0);
    rd(32'h10); step();
    chk("rd10_cleared", o_mem_rdata, 64'd0);
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
